// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Upstream driver for sequential_alu. Commands {a,b,sel} arrive on a
//   valid/ready port and wait in a small FIFO. They are issued to the ALU
//   inputs one at a time. Each registered ALU result comes back on a
//   valid/ready result port, together with an echo of its command.
//
//   Handshake rule (both ports): a transfer happens on a rising clk edge
//   where valid && ready are both 1. A valid source holds valid and its
//   payload stable until that transfer. ready may depend on state, but never
//   on valid in the same cycle.
//
// Ports
//   clk, reset               clock (rising edge); async active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_ready == !full
//   cmd_a, cmd_b, cmd_sel    command payload
//   alu_a, alu_b, alu_sel    registered drive into sequential_alu
//   alu_y                    registered result from sequential_alu
//   res_valid/res_ready      result handshake
//   res_y                    captured ALU result
//   res_a, res_b, res_sel    echo of the issued command
//   res_dz                   divide by zero (sel == 011 && b == 0)
//   ops_issued               count of issued commands, wraps at 2^CW
//   fsm_state                debug view of the sequencer state
//                            (0 IDLE, 1 DRIVE, 2 CAPTURE, 3 HOLD)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int DW    = 4,
   parameter int CW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [DW-1:0] cmd_a,
   input  logic [DW-1:0] cmd_b,
   input  logic [2:0]    cmd_sel,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_sel,
   input  logic [DW-1:0] alu_y,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_y,
   output logic [DW-1:0] res_a,
   output logic [DW-1:0] res_b,
   output logic [2:0]    res_sel,
   output logic          res_dz,
   output logic [CW-1:0] ops_issued,
   output logic [1:0]    fsm_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 * DW + 3;
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [CW-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DRIVE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t state, state_nx;

   // ------------------------------------------------------------------------
   // Command FIFO. The pointers carry one extra wrap bit, which tells full
   // apart from empty. cmd_ready comes from the registered pointers only.
   // A pop in the same cycle therefore never frees a slot for a push, so
   // there is no path from res_ready to cmd_ready.
   // ------------------------------------------------------------------------
   logic [EW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, push, pop;
   logic [DW-1:0] head_a, head_b;
   logic [2:0]    head_sel;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign {head_a, head_b, head_sel} = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_sel};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // ------------------------------------------------------------------------
   // FSM: outputs. issue pops the FIFO head onto the ALU inputs. From HOLD,
   // the result must be taken first, so the next command goes out on the
   // same edge as the result handshake.
   // ------------------------------------------------------------------------
   logic issue, res_hs;

   always_comb begin
      issue  = 1'b0;
      res_hs = 1'b0;
      case (state)
         S_IDLE: issue = !empty;
         S_HOLD: begin
            res_hs = res_valid && res_ready;
            issue  = res_hs && !empty;
         end
         default: ;
      endcase
   end

   assign pop       = issue;
   assign fsm_state = state;

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (issue) state_nx = S_DRIVE;
         S_DRIVE:   state_nx = S_CAPTURE;   // ALU samples alu_* at this edge
         S_CAPTURE: state_nx = S_HOLD;      // alu_y now holds the result
         S_HOLD:    if (res_hs) state_nx = issue ? S_DRIVE : S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath. alu_* change only on issue edges. Between operations they
   // keep the last command. res_* hold steady for the whole of HOLD.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         res_a      <= '0;
         res_b      <= '0;
         res_sel    <= '0;
         res_y      <= '0;
         res_dz     <= 1'b0;
         res_valid  <= 1'b0;
         ops_issued <= '0;
      end else begin
         if (issue) begin
            alu_a      <= head_a;
            alu_b      <= head_b;
            alu_sel    <= head_sel;
            res_a      <= head_a;
            res_b      <= head_b;
            res_sel    <= head_sel;
            ops_issued <= ops_issued + CNT_ONE;
         end
         if (state == S_CAPTURE) begin
            res_y     <= alu_y;
            res_dz    <= (alu_sel == 3'b011) && (alu_b == '0);
            res_valid <= 1'b1;
         end else if (res_hs) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Directed bench for alu_cmd_sequencer. A behavioural stand-in for
//   sequential_alu registers y from alu_a/b/sel on every clock edge.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled on
//   the falling edge, or 1 unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
   localparam int DW    = 4;
   localparam int CW    = 8;
   localparam int DEPTH = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b111;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0, cmd_ready;
   logic [DW-1:0] cmd_a = '0, cmd_b = '0;
   logic [2:0]    cmd_sel = '0;
   logic [DW-1:0] alu_a, alu_b, alu_y;
   logic [2:0]    alu_sel;
   logic          res_valid, res_ready = 1'b0;
   logic [DW-1:0] res_y, res_a, res_b;
   logic [2:0]    res_sel;
   logic          res_dz;
   logic [CW-1:0] ops_issued;
   logic [1:0]    fsm_state;

   alu_cmd_sequencer #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_y(res_y), .res_a(res_a), .res_b(res_b), .res_sel(res_sel),
      .res_dz(res_dz), .ops_issued(ops_issued), .fsm_state(fsm_state)
   );

   // ---------------- ALU stand-in ----------------
   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, b, input logic [2:0] sel);
      logic [DW-1:0] r;
      case (sel)
         3'b000:  r = a + b;
         3'b001:  r = a - b;
         3'b010:  r = a * b;
         3'b011:  r = (b == '0) ? '0 : a / b;
         3'b100:  r = a & b;
         3'b101:  r = a | b;
         3'b110:  r = a << 1;
         default: r = a ^ b;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) alu_y <= '0;
      else       alu_y <= alu_f(alu_a, alu_b, alu_sel);
   end

   // ---------------- scoreboard ----------------
   // entry = {a, b, sel, y, dz}
   logic [2*DW+3+DW:0] exp_q[$];
   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // The result handshake completes on the next rising edge. res_ready
   // changes only just after a rising edge.
   always @(negedge clk) begin
      if (!reset && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_unexpected: got a=%0h b=%0h sel=%0h y=%0h with nothing expected",
                     res_a, res_b, res_sel, res_y);
         end else begin
            check("sb_result", {res_a, res_b, res_sel, res_y, res_dz}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks (entered just after a rising edge) ----------------
   task automatic send(input logic [DW-1:0] a, b, input logic [2:0] sel,
                       input logic [DW-1:0] y, input logic dz);
      int w;
      cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: cmd_ready got 0 expected 1");
         @(posedge clk); #1;
         cmd_valid = 1'b0;
      end else begin
         exp_q.push_back({a, b, sel, y, dz});
         @(posedge clk); #1;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic send_m(input logic [DW-1:0] a, b, input logic [2:0] sel);
      send(a, b, sel, alu_f(a, b, sel), (sel == OP_DIV) && (b == '0));
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      while ((exp_q.size() != 0 || res_valid || fsm_state != 2'd0) && w < 400) begin
         @(posedge clk); #1;
         w++;
      end
      check(name, {31'd0, (exp_q.size() == 0 && !res_valid && fsm_state == 2'd0)}, 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cmd_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_alu"},  {alu_a, alu_b, alu_sel}, 32'd0);
      check({tag, "_res"},  {res_valid, res_y, res_a, res_b, res_sel, res_dz}, 32'd0);
      check({tag, "_ops"},  ops_issued, 32'd0);
      check({tag, "_rdy"},  cmd_ready, 32'd1);
      check({tag, "_fsm"},  fsm_state, 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [2:0]    sel;
      logic [DW-1:0] y;
      logic          dz;
   } vec_t;

   vec_t vecs[8];

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int n, acc, w;

      vecs[0] = '{4'd4,  4'd3,  OP_ADD, 4'd7,  1'b0};
      vecs[1] = '{4'd2,  4'd5,  OP_SUB, 4'd13, 1'b0};
      vecs[2] = '{4'd9,  4'd0,  OP_DIV, 4'd0,  1'b1};
      vecs[3] = '{4'd9,  4'd2,  OP_DIV, 4'd4,  1'b0};
      vecs[4] = '{4'd10, 4'd6,  OP_XOR, 4'd12, 1'b0};
      vecs[5] = '{4'd15, 4'd1,  OP_ADD, 4'd0,  1'b0};
      vecs[6] = '{4'd12, 4'd10, OP_AND, 4'd8,  1'b0};
      vecs[7] = '{4'd5,  4'd10, OP_OR,  4'd15, 1'b0};

      // Reset held from time 0
      #1;
      check_reset_state("rst0");
      @(posedge clk); #1;
      reset = 1'b0;

      // Single ADD and its latency
      res_ready = 1'b1;
      send(4'd4, 4'd3, OP_ADD, 4'd7, 1'b0);   // accepted at E0
      n = 0;
      @(negedge clk);
      while (!res_valid && n < 10) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check("lat_edges", n, 32'd3);
      check("lat_y", res_y, 32'd7);
      check("lat_sel", res_sel, 32'd0);
      check("lat_ops", ops_issued, 32'd1);
      @(posedge clk); #1;
      drain("drain_single");

      // Table of single operations
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].y, vecs[i].dz);
         drain("drain_vec");
      end
      check("hold_alu", {alu_a, alu_b, alu_sel}, {21'd0, vecs[7].a, vecs[7].b, vecs[7].sel});
      check("ops_after_table", ops_issued, 32'd9);

      // Reset asserted asynchronously in the middle of a cycle
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      check_reset_state("rst_mid");
      @(posedge clk); #1;
      reset = 1'b0;

      // Backpressure: six back-to-back commands, res_ready low
      res_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_a = 4'(i + 1); cmd_b = 4'(i + 2); cmd_sel = 3'(i); cmd_valid = 1'b1;
         @(negedge clk);
         if (!cmd_ready) break;
         exp_q.push_back({cmd_a, cmd_b, cmd_sel, alu_f(cmd_a, cmd_b, cmd_sel),
                          (cmd_sel == OP_DIV) && (cmd_b == '0)});
         acc++;
         @(posedge clk); #1;
      end
      check("bp_accepted", acc, 32'd5);
      repeat (5) @(posedge clk);
      #1;
      check("bp_full", cmd_ready, 32'd0);
      check("bp_fsm_hold", fsm_state, 32'd3);
      res_ready = 1'b1;
      w = 1;
      @(negedge clk);
      while (!cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("bp_sixth_wait", w, 32'd2);
      if (cmd_ready) begin
         exp_q.push_back({cmd_a, cmd_b, cmd_sel, alu_f(cmd_a, cmd_b, cmd_sel),
                          (cmd_sel == OP_DIV) && (cmd_b == '0)});
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      drain("drain_bp");

      // Push on the same edge as the HOLD->DRIVE handshake
      res_ready = 1'b0;
      send_m(4'd3, 4'd4, OP_ADD);
      send_m(4'd8, 4'd2, OP_DIV);
      send_m(4'd7, 4'd7, OP_XOR);
      w = 0;
      while (fsm_state != 2'd3 && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check("pp_in_hold", fsm_state, 32'd3);
      res_ready = 1'b1;
      cmd_a = 4'd6; cmd_b = 4'd0; cmd_sel = OP_DIV; cmd_valid = 1'b1;
      @(negedge clk);
      check("pp_ready", cmd_ready, 32'd1);
      exp_q.push_back({4'd6, 4'd0, OP_DIV, 4'd0, 1'b1});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      check("pp_fsm_drive", fsm_state, 32'd1);
      // Two entries remain queued, so exactly two more fit
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         cmd_a = 4'(i + 11); cmd_b = 4'(i + 1); cmd_sel = OP_SUB; cmd_valid = 1'b1;
         @(negedge clk);
         if (!cmd_ready) break;
         exp_q.push_back({cmd_a, cmd_b, cmd_sel, alu_f(cmd_a, cmd_b, cmd_sel), 1'b0});
         acc++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("pp_room", acc, 32'd2);
      res_ready = 1'b1;
      drain("drain_pp");

      // Reset while a command is in DRIVE: that command is dropped
      do_reset();
      send_m(4'd5, 4'd5, OP_ADD);
      @(posedge clk); #1;
      check("rd_fsm_drive", fsm_state, 32'd1);
      #2 reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      send(4'd1, 4'd1, OP_ADD, 4'd2, 1'b0);
      drain("drain_rd");
      check("rd_ops", ops_issued, 32'd1);
      check("rd_res_y", res_y, 32'd2);

      // Issued-op counter wrap
      do_reset();
      for (int i = 0; i < 255; i++) begin
         send_m(4'(i), 4'(i >> 4), 3'(i));
      end
      drain("drain_wrap");
      check("ops_255", ops_issued, 32'd255);
      send_m(4'd3, 4'd3, OP_ADD);
      drain("drain_wrap2");
      check("ops_wrap", ops_issued, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
